nx_mesh_egress: RTL and testbench



---
 rtl/nx_mesh_egress_pkg.sv | 25 ++
 rtl/nx_egress_fifo.sv | 67 ++++++
 rtl/nx_mesh_egress.sv | 124 ++++++++++++
 tb/tb_nx_mesh_egress.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nx_mesh_egress_pkg.sv
// NXConstants: mesh-wide message format and direction encoding, plus the
// layout of one egress buffer entry (source channel tagged onto a message).
package NXConstants;

  localparam int MESSAGE_WIDTH  = 32;
  localparam int NUM_DIRECTIONS = 4;
  localparam int CHAN_W         = $clog2(NUM_DIRECTIONS);

  typedef logic [MESSAGE_WIDTH-1:0] node_message_t;

  // Channel index of each edge-node link when one node drives the collector.
  typedef enum logic [CHAN_W-1:0] {
    DIRECTION_NORTH = 2'd0,
    DIRECTION_EAST  = 2'd1,
    DIRECTION_SOUTH = 2'd2,
    DIRECTION_WEST  = 2'd3
  } direction_t;

  // One buffered message with the channel it arrived on.
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    node_message_t     message;
  } egress_entry_t;

endpackage

// File: rtl/nx_egress_fifo.sv
// nx_egress_fifo: synchronous first-word-fall-through FIFO.
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_push, i_data    write request and data (ignored while full)
//   i_pop             consume head (ignored while empty)
//   o_data, o_valid   head entry and its valid (o_data reads 0 when empty)
//   o_full, o_count   registered full flag and occupancy
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module nx_egress_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             empty_q, full_q;
  logic             push_ok, pop_ok;

  assign push_ok = i_push & ~full_q;
  assign pop_ok  = i_pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage has no reset; the reset pointers/flags already mark every
  // entry invalid, and leaving the array unreset lets it map to plain RAM.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  // Head is masked while empty so stale storage never reaches the outputs.
  assign o_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign o_valid = ~empty_q;
  assign o_full  = full_q;
  assign o_count = count_q;

endmodule

// File: rtl/nx_mesh_egress.sv
// nx_mesh_egress: collector terminating the outbound links of the edge nodes.
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_enable / o_present         per-channel enable, registered presence
//   i_in_data/i_in_valid/o_in_ready  per-channel inbound valid/ready links
//   o_out_data/o_out_chan/o_out_valid/i_out_ready  host-side stream
//   o_received                   saturating count of accepted messages
//   o_idle                       nothing buffered and no present channel valid
// Round-robin arbitration admits at most one channel per cycle into a FWFT
// FIFO whose entries carry the source channel.
module nx_mesh_egress
  import NXConstants::*;
#(
  parameter  int CHANNELS   = 4,
  parameter  int FIFO_DEPTH = 8,
  parameter  int COUNT_W    = 32,
  localparam int CW         = $clog2(CHANNELS)
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [CHANNELS-1:0]                     i_enable,
  output logic [CHANNELS-1:0]                     o_present,
  input  logic [CHANNELS-1:0][MESSAGE_WIDTH-1:0]  i_in_data,
  input  logic [CHANNELS-1:0]                     i_in_valid,
  output logic [CHANNELS-1:0]                     o_in_ready,
  output logic [MESSAGE_WIDTH-1:0]                o_out_data,
  output logic [CW-1:0]                           o_out_chan,
  output logic                                    o_out_valid,
  input  logic                                    i_out_ready,
  output logic [COUNT_W-1:0]                      o_received,
  output logic                                    o_idle
);

  localparam int EW = $bits(egress_entry_t);
  localparam int FW = $clog2(FIFO_DEPTH);

  logic [CHANNELS-1:0] present_q;
  logic [CHANNELS-1:0] cand;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       grant_idx;
  logic                grant_vld;
  int unsigned         scan_idx;
  logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [COUNT_W-1:0]  received_q, received_d;
  logic                fifo_full, fifo_valid;
  logic [FW:0]         fifo_count;
  egress_entry_t       push_entry, head_entry;

  assign cand = i_in_valid & present_q;

  // Scan from the pointer upward with wrap; first candidate wins. The full
  // flag is registered, so a pop this cycle cannot open a slot this cycle.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    if (!fifo_full) begin
      for (int k = 0; k < CHANNELS; k++) begin
        scan_idx = (int'(rr_ptr_q) + k) % CHANNELS;
        if (!grant_vld && cand[scan_idx]) begin
          grant_vld       = 1'b1;
          grant_idx       = CW'(scan_idx);
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld)
      rr_ptr_d = (grant_idx == CW'(CHANNELS-1)) ? '0 : grant_idx + CW'(1);
  end

  always_comb begin
    received_d = received_q;
    if (grant_vld && received_q != '1) received_d = received_q + COUNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      present_q  <= '0;
      rr_ptr_q   <= '0;
      received_q <= '0;
    end else begin
      present_q  <= i_enable;
      rr_ptr_q   <= rr_ptr_d;
      received_q <= received_d;
    end
  end

  always_comb begin
    push_entry         = '0;
    push_entry.chan    = CHAN_W'(grant_idx);
    push_entry.message = i_in_data[grant_idx];
  end

  nx_egress_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (grant_vld),
    .i_data  (push_entry),
    .i_pop   (i_out_ready),
    .o_data  (head_entry),
    .o_valid (fifo_valid),
    .o_full  (fifo_full),
    .o_count (fifo_count)
  );

  assign o_present   = present_q;
  assign o_in_ready  = grant;
  assign o_out_valid = fifo_valid;
  assign o_out_data  = head_entry.message;
  assign o_out_chan  = head_entry.chan[CW-1:0];
  assign o_received  = received_q;
  assign o_idle      = (fifo_count == '0) && (cand == '0);

endmodule

// File: tb/tb_nx_mesh_egress.sv
// Bench for nx_mesh_egress: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model.
module tb_nx_mesh_egress;

  localparam int CH    = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        i_enable = '0;
  logic [3:0]        o_present;
  logic [3:0][31:0]  i_in_data = '0;
  logic [3:0]        i_in_valid = '0;
  logic [3:0]        o_in_ready;
  logic [31:0]       o_out_data;
  logic [1:0]        o_out_chan;
  logic              o_out_valid;
  logic              i_out_ready = 1'b0;
  logic [CNT_W-1:0]  o_received;
  logic              o_idle;

  always #5 clk = ~clk;

  nx_mesh_egress #(
    .CHANNELS   (CH),
    .FIFO_DEPTH (DEPTH),
    .COUNT_W    (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (i_enable),
    .o_present   (o_present),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_chan  (o_out_chan),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_received  (o_received),
    .o_idle      (o_idle)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [33:0] q[$];
  int          ptr_m;
  int          rcv_m;
  logic [3:0]  pres_m;
  logic [3:0]  obs_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare 1 ns later, advance the model
  // for the coming posedge.
  task automatic cycle(input logic [3:0] en, input logic [3:0] vld,
                       input logic [3:0][31:0] dat, input logic ordy);
    logic [3:0] cand;
    logic [3:0] exp_rdy;
    int         win;
    @(negedge clk);
    i_enable    = en;
    i_in_valid  = vld;
    i_in_data   = dat;
    i_out_ready = ordy;
    #1;
    cand    = vld & pres_m;
    exp_rdy = '0;
    win     = -1;
    if (q.size() < DEPTH)
      for (int k = 0; k < CH; k++)
        if (win < 0 && cand[(ptr_m + k) % CH]) win = (ptr_m + k) % CH;
    if (win >= 0) exp_rdy[win] = 1'b1;
    obs_rdy = o_in_ready;
    check("present", o_present, pres_m);
    check("in_ready", o_in_ready, exp_rdy);
    check("out_valid", o_out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", o_out_data, q[0][31:0]);
      check("out_chan", o_out_chan, q[0][33:32]);
    end
    check("idle", o_idle, (q.size() == 0) && (cand == 4'b0));
    check("received", o_received, rcv_m);
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (win >= 0) begin
      q.push_back({2'(win), dat[win]});
      ptr_m = (win + 1) % CH;
      if (rcv_m < SAT) rcv_m++;
    end
    pres_m = en;
  endtask

  // Assert reset mid-cycle, check outputs immediately, release a cycle later.
  task automatic do_reset(input logic [3:0] en);
    @(negedge clk);
    rst = 1'b0;
    i_in_valid  = '0;
    i_enable    = en;
    i_out_ready = 1'b0;
    #1;
    check("rst_out_valid", o_out_valid, 1'b0);
    check("rst_received", o_received, '0);
    check("rst_present", o_present, '0);
    check("rst_in_ready", o_in_ready, '0);
    check("rst_idle", o_idle, 1'b1);
    check("rst_out_data", o_out_data, '0);
    check("rst_out_chan", o_out_chan, '0);
    @(negedge clk);
    #1;
    check("rst_present_hold", o_present, '0);
    rst = 1'b1;
    q.delete();
    ptr_m  = 0;
    rcv_m  = 0;
    pres_m = en;  // the posedge before the next cycle registers en
  endtask

  logic [3:0][31:0] d;
  int               gcnt[4];
  int               sent;
  int               nv;
  logic [3:0]       ven;

  initial begin
    d = '0;

    // Reset and presence: channel 2 never readied.
    do_reset(4'b1011);
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) d[c] = $urandom;
      cycle(4'b1011, 4'b1111, d, 1'b1);
      check("ch2_never_ready", obs_rdy[2], 1'b0);
    end

    // Single message from channel 1.
    do_reset(4'b1111);
    d = '0;
    d[1] = 32'h1234_5678;
    cycle(4'b1111, 4'b0010, d, 1'b1);
    check("single_accept", obs_rdy, 4'b0010);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b0000, d, 1'b1);
    check("single_received", o_received, 1);

    // Round-robin fairness over 100 accepts.
    do_reset(4'b1111);
    for (int c = 0; c < 4; c++) gcnt[c] = 0;
    for (int i = 0; i < 100; i++) begin
      for (int c = 0; c < 4; c++) d[c] = $urandom;
      cycle(4'b1111, 4'b1111, d, 1'b1);
      for (int c = 0; c < 4; c++) if (obs_rdy[c]) gcnt[c]++;
    end
    for (int c = 0; c < 4; c++) check("rr_share", gcnt[c], 25);

    // Full back-pressure: 10 offered, 8 fit, rest follow the first pop.
    do_reset(4'b1111);
    sent = 0;
    d = '0;
    for (int i = 0; i < 12; i++) begin
      d[0] = 32'hA000_0000 + sent;
      cycle(4'b1111, {3'b000, sent < 10}, d, 1'b0);
      if (obs_rdy[0]) sent++;
    end
    check("full_accepts", sent, 8);
    for (int i = 0; i < 20; i++) begin
      d[0] = 32'hA000_0000 + sent;
      cycle(4'b1111, {3'b000, sent < 10}, d, 1'b1);
      if (obs_rdy[0]) sent++;
    end
    check("full_total", sent, 10);

    // Simultaneous push/pop at occupancy 4.
    do_reset(4'b1111);
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[3] = 32'hB000_0000 + i;
      cycle(4'b1111, 4'b1000, d, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      d[3] = 32'hC000_0000 + i;
      cycle(4'b1111, 4'b1000, d, 1'b1);
    end
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 4'b0000, d, 1'b1);
      if (o_out_valid) nv++;
    end
    check("pushpop_depth", nv, 4);

    // Counter saturation, then reset with entries buffered.
    do_reset(4'b1111);
    for (int i = 0; i < 20; i++) begin
      d = '0;
      d[i % 4] = $urandom;
      cycle(4'b1111, 4'(1 << (i % 4)), d, 1'b1);
    end
    cycle(4'b1111, 4'b0000, d, 1'b1);
    check("saturated", o_received, SAT);
    for (int i = 0; i < 3; i++) begin
      d[1] = 32'hD000_0000 + i;
      cycle(4'b1111, 4'b0010, d, 1'b0);
    end
    do_reset(4'b1111);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b0000, d, 1'b1);

    // Random traffic with presence changes and host stalls.
    do_reset(4'b1111);
    for (int i = 0; i < 600; i++) begin
      ven = 4'($urandom) | 4'($urandom);
      for (int c = 0; c < 4; c++) d[c] = $urandom;
      cycle(ven, 4'($urandom), d, ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                       : ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
